rom_wb_arbiter: RTL and testbench

- Shares the wishbone backdoor ports of up to NUM_ROMS rom chips between two wishbone masters.
  - m0: host loader, e.g. the SPI/UART program loader.
  - m1: debug/monitor.
- Round-robin arbitration; address-decoded chip select; one-shot strobe per transaction; timeout error.
- Sits between the loader fabric and the rom instances. ROM backdoor acks arrive late (once per 8-cycle bus frame), so the arbiter holds the slave request until ack.

---
 rtl/rom_bus_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/rom_wb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rom_wb_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_bus_pkg.sv
// Shared definitions for the rom backdoor wishbone fabric.
// Holds the bus widths, the arbiter state encoding and the rom window size
// used both by the arbiter decode and by the loader address map.
package rom_bus_pkg;

  localparam int WB_DATA_W            = 32;
  localparam int WB_ADDR_W            = 32;
  localparam int ROM_CAPACITY_DEFAULT = 256;
  // One byte per 32-bit word, so each rom spans four bytes of address per entry.
  localparam int ROM_WINDOW_BYTES     = 4 * ROM_CAPACITY_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_t;

  function automatic int rom_window_bytes(input int capacity);
    return 4 * capacity;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   req[1:0]      - live requests from master 0 / master 1
//   update        - a transaction owned by done_idx has finished
//   done_idx      - master that just finished (becomes last_grant)
//   grant_valid   - at least one request is present
//   grant_idx     - master to serve this cycle
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       done_idx,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Resets to master 1 so that master 0 wins the very first tie.
  logic last_grant_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (update) begin
      last_grant_reg <= done_idx;
    end
  end

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    unique case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_reg;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/rom_wb_arbiter.sv
// Shares the wishbone backdoor ports of NUM_ROMS rom chips between two
// masters (m0 loader, m1 debug monitor).
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   mN_cyc/stb/we/addr/data_i - master N wishbone request
//   mN_data_o, mN_ack_o, mN_err_o - master N response (one-cycle pulses)
//   s_cyc_o, s_stb_o        - per-rom cycle / strobe, one-hot while busy
//   s_we_o, s_addr_o, s_data_o - shared request, address relative to window
//   s_data_i, s_ack_i       - per-rom read data (rom k at [32k+31:32k]) / acks
// Rom acks arrive once per 8-cycle bus frame, so the slave request is held
// until the selected rom acks, the granted master aborts, or the timeout hits.
module rom_wb_arbiter
  import rom_bus_pkg::*;
#(
  parameter int NUM_ROMS       = 4,
  parameter int ROM_CAPACITY   = 256,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [WB_ADDR_W-1:0]      m0_addr_i,
  input  logic [WB_DATA_W-1:0]      m0_data_i,
  output logic [WB_DATA_W-1:0]      m0_data_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [WB_ADDR_W-1:0]      m1_addr_i,
  input  logic [WB_DATA_W-1:0]      m1_data_i,
  output logic [WB_DATA_W-1:0]      m1_data_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic [NUM_ROMS-1:0]       s_cyc_o,
  output logic [NUM_ROMS-1:0]       s_stb_o,
  output logic                      s_we_o,
  output logic [WB_ADDR_W-1:0]      s_addr_o,
  output logic [WB_DATA_W-1:0]      s_data_o,
  input  logic [WB_DATA_W*NUM_ROMS-1:0] s_data_i,
  input  logic [NUM_ROMS-1:0]       s_ack_i
);

  localparam int WIN_BITS = $clog2(ROM_CAPACITY) + 2;
  localparam int SEL_BITS = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1;
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);
  // One bit wider than the address so the limit itself cannot wrap.
  localparam logic [WB_ADDR_W:0]   ADDR_LIMIT  = (WB_ADDR_W+1)'(NUM_ROMS * rom_window_bytes(ROM_CAPACITY));
  localparam logic [WB_ADDR_W-1:0] OFFSET_MASK = (WB_ADDR_W'(1) << WIN_BITS) - WB_ADDR_W'(1);
  localparam logic [CNT_BITS-1:0]  CNT_LAST    = CNT_BITS'(TIMEOUT_CYCLES - 1);

  arb_state_t state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 we_reg, we_next;
  logic [WB_ADDR_W-1:0] addr_reg, addr_next;
  logic [WB_DATA_W-1:0] wdata_reg, wdata_next;
  logic [WB_DATA_W-1:0] rdata_reg, rdata_next;
  logic [SEL_BITS-1:0]  sel_reg, sel_next;
  logic [CNT_BITS-1:0]  cnt_reg, cnt_next;

  logic                 arb_valid, arb_idx, arb_update;
  logic [1:0]           req;
  logic                 m_we    [2];
  logic [WB_ADDR_W-1:0] m_addr  [2];
  logic [WB_DATA_W-1:0] m_wdata [2];
  logic [WB_DATA_W-1:0] rom_rdata [NUM_ROMS];
  logic                 granted_cyc;
  logic                 busy;

  assign req        = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign m_we[0]    = m0_we_i;
  assign m_we[1]    = m1_we_i;
  assign m_addr[0]  = m0_addr_i;
  assign m_addr[1]  = m1_addr_i;
  assign m_wdata[0] = m0_data_i;
  assign m_wdata[1] = m1_data_i;
  assign granted_cyc = grant_reg ? m1_cyc_i : m0_cyc_i;
  assign busy        = (state_reg == ST_BUSY);

  rr_arbiter2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .update      (arb_update),
    .done_idx    (grant_reg),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // Per-rom fan-out of the decoded select and fan-in of read data.
  generate
    for (genvar gi = 0; gi < NUM_ROMS; gi++) begin : g_rom
      assign rom_rdata[gi] = s_data_i[WB_DATA_W*gi +: WB_DATA_W];
      assign s_cyc_o[gi]   = busy && (sel_reg == SEL_BITS'(gi));
      assign s_stb_o[gi]   = busy && (sel_reg == SEL_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      sel_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    arb_update = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_next = arb_idx;
          we_next    = m_we[arb_idx];
          addr_next  = m_addr[arb_idx] & OFFSET_MASK;
          wdata_next = m_wdata[arb_idx];
          sel_next   = m_addr[arb_idx][WIN_BITS +: SEL_BITS];
          cnt_next   = '0;
          // Out-of-window requests never touch a rom.
          state_next = ({1'b0, m_addr[arb_idx]} >= ADDR_LIMIT) ? ST_ERR : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!granted_cyc) begin
          // Master gave up: release the bus silently but still rotate priority.
          arb_update = 1'b1;
          state_next = ST_IDLE;
        end else if (s_ack_i[sel_reg]) begin
          rdata_next = rom_rdata[sel_reg];
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CNT_BITS'(1);
        end
      end
      // Strobes are low here, so the rom sees the request drop before its
      // next frame and cannot repeat a write.
      ST_RESP: begin
        arb_update = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        arb_update = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign s_we_o    = busy & we_reg;
  assign s_addr_o  = busy ? addr_reg  : '0;
  assign s_data_o  = busy ? wdata_reg : '0;
  assign m0_data_o = rdata_reg;
  assign m1_data_o = rdata_reg;
  assign m0_ack_o  = (state_reg == ST_RESP) && !grant_reg;
  assign m1_ack_o  = (state_reg == ST_RESP) &&  grant_reg;
  assign m0_err_o  = (state_reg == ST_ERR)  && !grant_reg;
  assign m1_err_o  = (state_reg == ST_ERR)  &&  grant_reg;

endmodule

// File: tb/tb_rom_wb_arbiter.sv
module tb_rom_wb_arbiter;

  localparam int NR       = 4;
  localparam int ROM_CAP  = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0, m0_data_o;
  logic m0_ack_o, m0_err_o;
  logic m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_addr_i = 0, m1_data_i = 0, m1_data_o;
  logic m1_ack_o, m1_err_o;
  logic [NR-1:0] s_cyc_o, s_stb_o, s_ack_i;
  logic s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [32*NR-1:0] s_data_i;

  rom_wb_arbiter #(.NUM_ROMS(NR), .ROM_CAPACITY(ROM_CAP), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  always #5 clock = ~clock;

  // ---------------- environment: cycle counter, rom bfm, pulse monitor ----
  int       cyc_cnt = 0;
  bit [2:0] frame_cnt = 3'd0;   // rom bus frame position, equals cyc_cnt % 8
  int       bfm_mode = 0;       // 0: ack at frame slot 7, 1: ack after ack_delay strobe cycles, 2: never
  int       ack_delay = 5;
  bit       bfm_clear = 1'b1;
  logic [7:0] rom_mem [NR][256];
  int       stb_run [NR];
  int       wr_count = 0;
  int       mon_acks [2];
  int       mon_errs [2];

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clock) begin
    frame_cnt <= frame_cnt + 3'd1;
    if (bfm_clear) begin
      for (int r = 0; r < NR; r++) begin
        for (int w = 0; w < 256; w++) rom_mem[r][w] <= 8'h00;
        stb_run[r] <= 0;
      end
      s_ack_i  <= '0;
      s_data_i <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (s_cyc_o[r] && s_stb_o[r] && !s_ack_i[r]) begin
          stb_run[r] <= stb_run[r] + 1;
          if ((bfm_mode == 0 && frame_cnt == 3'd7) || (bfm_mode == 1 && stb_run[r] + 1 >= ack_delay)) begin
            s_ack_i[r] <= 1'b1;
            s_data_i[32*r +: 32] <= {24'h0, rom_mem[r][s_addr_o[9:2]]};
            if (s_we_o) begin
              rom_mem[r][s_addr_o[9:2]] <= s_data_o[7:0];
              wr_count <= wr_count + 1;
            end
          end else begin
            s_ack_i[r] <= 1'b0;
          end
        end else begin
          s_ack_i[r] <= 1'b0;
          if (!s_stb_o[r]) stb_run[r] <= 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (m0_ack_o) mon_acks[0] <= mon_acks[0] + 1;
      if (m1_ack_o) mon_acks[1] <= mon_acks[1] + 1;
      if (m0_err_o) mon_errs[0] <= mon_errs[0] + 1;
      if (m1_err_o) mon_errs[1] <= mon_errs[1] + 1;
    end
  end

  // ---------------- reference model: rom contents and round-robin owner ----
  logic [7:0] ref_mem [NR][256];
  int model_last = 1;
  int exp_acks [2];
  int exp_errs [2];
  int n_pass = 0;
  int n_total = 0;

  task automatic model_txn(input int m, input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output logic exp_err, output logic [31:0] exp_rd);
    int r, w;
    exp_rd = 32'h0;
    if (addr >= 32'(NR * 4 * ROM_CAP)) begin
      exp_err = 1'b1;
      exp_errs[m]++;
    end else begin
      exp_err = 1'b0;
      r = int'(addr / (4 * ROM_CAP));
      w = int'((addr % (4 * ROM_CAP)) / 4);
      exp_rd = {24'h0, ref_mem[r][w]};
      if (we) ref_mem[r][w] = data[7:0];
      exp_acks[m]++;
    end
    model_last = m;
  endtask

  // ---------------- master drivers ----------------
  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_cyc_i = req; m0_stb_i = req; m0_we_i = we; m0_addr_i = addr; m0_data_i = data;
    end else begin
      m1_cyc_i = req; m1_stb_i = req; m1_we_i = we; m1_addr_i = addr; m1_data_i = data;
    end
  endtask

  task automatic master_txn(input int m, input logic we, input logic [31:0] addr, input logic [31:0] data,
                            output logic got_ack, output logic got_err, output logic [31:0] rdata,
                            output int start_cyc, output int done_cyc);
    got_ack = 1'b0; got_err = 1'b0; rdata = 32'h0; done_cyc = -1;
    @(negedge clock);
    drive(m, 1'b1, we, addr, data);
    start_cyc = cyc_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m == 0 ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o)) begin
        got_ack  = (m == 0) ? m0_ack_o : m1_ack_o;
        got_err  = (m == 0) ? m0_err_o : m1_err_o;
        rdata    = (m == 0) ? m0_data_o : m1_data_o;
        done_cyc = cyc_cnt;
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic run_single(input int m, input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic ga, ge, xe;
    logic [31:0] rd, xrd;
    int sc, dc;
    master_txn(m, we, addr, data, ga, ge, rd, sc, dc);
    model_txn(m, we, addr, data, xe, xrd);
    n_total++;
    if ({ga, ge} !== {~xe, xe}) $display("FAIL single_resp m%0d addr=%h: ack/err=%b%b, expected %b%b", m, addr, ga, ge, ~xe, xe);
    else n_pass++;
    if (!we && !xe) begin
      n_total++;
      if (rd !== xrd) $display("FAIL single_rdata m%0d addr=%h: got %h, expected %h", m, addr, rd, xrd);
      else n_pass++;
    end
    $display("txn m%0d we=%0b addr=%h data=%h -> ack=%0b err=%0b rdata=%h", m, we, addr, data, ga, ge, rd);
  endtask

  task automatic run_pair(input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    logic ga [2], ge [2], xe [2], wev [2];
    logic [31:0] rd [2], xrd [2], av [2], dv [2];
    int sc [2], dc [2];
    int first, second;
    wev[0] = we0; av[0] = a0; dv[0] = d0;
    wev[1] = we1; av[1] = a1; dv[1] = d1;
    fork
      master_txn(0, we0, a0, d0, ga[0], ge[0], rd[0], sc[0], dc[0]);
      master_txn(1, we1, a1, d1, ga[1], ge[1], rd[1], sc[1], dc[1]);
    join
    first  = (model_last == 1) ? 0 : 1;
    second = 1 - first;
    model_txn(first,  wev[first],  av[first],  dv[first],  xe[first],  xrd[first]);
    model_txn(second, wev[second], av[second], dv[second], xe[second], xrd[second]);
    n_total++;
    if (!(dc[first] >= 0 && dc[first] < dc[second]))
      $display("FAIL pair_order: m%0d done at %0d, m%0d done at %0d, expected m%0d first", first, dc[first], second, dc[second], first);
    else n_pass++;
    for (int m = 0; m < 2; m++) begin
      n_total++;
      if ({ga[m], ge[m]} !== {~xe[m], xe[m]}) $display("FAIL pair_resp m%0d: ack/err=%b%b, expected %b%b", m, ga[m], ge[m], ~xe[m], xe[m]);
      else n_pass++;
      if (!wev[m] && !xe[m]) begin
        n_total++;
        if (rd[m] !== xrd[m]) $display("FAIL pair_rdata m%0d: got %h, expected %h", m, rd[m], xrd[m]);
        else n_pass++;
      end
    end
    $display("pair m0(%h) m1(%h) -> first m%0d, ack=%0b%0b err=%0b%0b", a0, a1, first, ga[0], ga[1], ge[0], ge[1]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bfm_clear = 1'b0;
    model_last = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_total++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== '0) $display("FAIL reset_slave_ctl: cyc=%b stb=%b we=%b, expected zeros", s_cyc_o, s_stb_o, s_we_o);
    else n_pass++;
    n_total++;
    if ({s_addr_o, s_data_o} !== 64'h0) $display("FAIL reset_slave_bus: addr=%h data=%h, expected 0", s_addr_o, s_data_o);
    else n_pass++;
    n_total++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_data_o, m1_data_o} !== '0)
      $display("FAIL reset_master: ack/err=%b%b%b%b data=%h/%h, expected zeros", m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_data_o, m1_data_o);
    else n_pass++;
    $display("reset: outputs checked idle");
  endtask

  task automatic test_write_basic();
    int slave_ack_cyc, mack_cyc, acks;
    logic xe;
    logic [31:0] xrd;
    slave_ack_cyc = -1; mack_cyc = -1; acks = 0;
    bfm_mode = 1; ack_delay = 5;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h414, 32'hA5);
    @(negedge clock);
    n_total++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== {4'b0010, 4'b0010, 1'b1})
      $display("FAIL wr_ctl: cyc=%b stb=%b we=%b, expected 0010 0010 1", s_cyc_o, s_stb_o, s_we_o);
    else n_pass++;
    n_total++;
    if ({s_addr_o, s_data_o} !== {32'h14, 32'hA5}) $display("FAIL wr_bus: addr=%h data=%h, expected 00000014 000000a5", s_addr_o, s_data_o);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      if (s_ack_i[1] && slave_ack_cyc < 0) slave_ack_cyc = cyc_cnt;
      if (m0_ack_o) begin
        acks++;
        if (mack_cyc < 0) mack_cyc = cyc_cnt;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      @(negedge clock);
    end
    model_txn(0, 1'b1, 32'h414, 32'hA5, xe, xrd);
    n_total++;
    if (acks !== 1) $display("FAIL wr_ack_count: got %0d pulses, expected 1", acks);
    else n_pass++;
    n_total++;
    if (!(slave_ack_cyc >= 0 && mack_cyc == slave_ack_cyc + 1))
      $display("FAIL wr_ack_latency: slave ack cycle %0d, master ack cycle %0d, expected one later", slave_ack_cyc, mack_cyc);
    else n_pass++;
    n_total++;
    if (rom_mem[1][5] !== ref_mem[1][5]) $display("FAIL wr_mem: rom1 word5=%h, expected %h", rom_mem[1][5], ref_mem[1][5]);
    else n_pass++;
    $display("write_basic: slave ack %0d master ack %0d pulses %0d", slave_ack_cyc, mack_cyc, acks);
  endtask

  task automatic test_fairness();
    int d0 [3], d1 [3];
    logic ga0 [3], ga1 [3], ge0 [3], ge1 [3], xe;
    logic [31:0] rd, xrd;
    int sc;
    do_reset();
    bfm_mode = 0;
    fork
      for (int i = 0; i < 3; i++) master_txn(0, 1'b1, 32'h000 + 32'((8 + i) * 4), 32'(8'h10 + i), ga0[i], ge0[i], rd, sc, d0[i]);
      for (int k = 0; k < 3; k++) master_txn(1, 1'b1, 32'h400 + 32'((8 + k) * 4), 32'(8'h20 + k), ga1[k], ge1[k], rd, sc, d1[k]);
    join
    for (int i = 0; i < 3; i++) begin
      model_txn(0, 1'b1, 32'h000 + 32'((8 + i) * 4), 32'(8'h10 + i), xe, xrd);
      model_txn(1, 1'b1, 32'h400 + 32'((8 + i) * 4), 32'(8'h20 + i), xe, xrd);
      n_total++;
      if (!(ga0[i] && ga1[i] && !ge0[i] && !ge1[i])) $display("FAIL fair_resp round %0d: ack m0/m1=%b%b, expected 11", i, ga0[i], ga1[i]);
      else n_pass++;
      n_total++;
      if (!(d0[i] >= 0 && d0[i] < d1[i])) $display("FAIL fair_order round %0d: m0 done %0d, m1 done %0d, expected m0 first", i, d0[i], d1[i]);
      else n_pass++;
      if (i < 2) begin
        n_total++;
        if (!(d1[i] < d0[i+1])) $display("FAIL fair_alternate round %0d: m1 done %0d, next m0 done %0d, expected m1 first", i, d1[i], d0[i+1]);
        else n_pass++;
      end
      $display("fairness round %0d: m0 done %0d m1 done %0d", i, d0[i], d1[i]);
    end
  endtask

  task automatic test_err_range();
    logic saw_err, saw_ack, saw_stb, xe;
    logic [31:0] xrd;
    saw_err = 0; saw_ack = 0; saw_stb = 0;
    @(negedge clock);
    drive(1, 1'b1, 1'b0, 32'h1000, 32'h0);
    for (int i = 0; i < 40 && !saw_err; i++) begin
      @(negedge clock);
      if (|s_stb_o) saw_stb = 1;
      if (m1_ack_o) saw_ack = 1;
      if (m1_err_o) saw_err = 1;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_txn(1, 1'b0, 32'h1000, 32'h0, xe, xrd);
    n_total++;
    if ({saw_err, saw_ack, saw_stb} !== {xe, 1'b0, 1'b0})
      $display("FAIL err_range: err/ack/stb=%b%b%b, expected %b00", saw_err, saw_ack, saw_stb, xe);
    else n_pass++;
    $display("err_range: err=%0b ack=%0b stb=%0b", saw_err, saw_ack, saw_stb);
  endtask

  task automatic test_timeout();
    int stb_cycles;
    logic saw_err, saw_ack;
    stb_cycles = 0; saw_err = 0; saw_ack = 0;
    bfm_mode = 2;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h808, 32'h77);
    for (int i = 0; i < 60 && !saw_err; i++) begin
      @(negedge clock);
      if (s_stb_o[2]) stb_cycles++;
      if (m0_ack_o) saw_ack = 1;
      if (m0_err_o) saw_err = 1;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_errs[0]++;
    model_last = 0;
    n_total++;
    if (stb_cycles !== 16) $display("FAIL timeout_stb_len: strobe held %0d cycles, expected 16", stb_cycles);
    else n_pass++;
    n_total++;
    if ({saw_err, saw_ack} !== 2'b10) $display("FAIL timeout_resp: err/ack=%b%b, expected 10", saw_err, saw_ack);
    else n_pass++;
    $display("timeout: strobe cycles %0d err=%0b", stb_cycles, saw_err);
    bfm_mode = 0;
    run_single(1, 1'b0, 32'h808, 32'h0);
  endtask

  task automatic test_abort();
    bfm_mode = 2;
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'h020, 32'h0);
    @(negedge clock);
    n_total++;
    if (s_stb_o !== 4'b0001) $display("FAIL abort_busy_stb: stb=%b, expected 0001", s_stb_o);
    else n_pass++;
    repeat (2) @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    n_total++;
    if ({s_stb_o, m0_ack_o, m0_err_o} !== 6'b0) $display("FAIL abort_release: stb=%b ack=%b err=%b, expected all 0", s_stb_o, m0_ack_o, m0_err_o);
    else n_pass++;
    $display("abort: bus released");
    model_last = 0;
    bfm_mode = 0;
    run_pair(1'b0, 32'h020, 32'h0, 1'b0, 32'h420, 32'h0);
  endtask

  task automatic test_reset_mid();
    int acks;
    logic xe;
    logic [31:0] xrd;
    acks = 0;
    bfm_mode = 2;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h010, 32'h3C);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m0_ack_o, m0_err_o} !== '0)
      $display("FAIL reset_mid_outputs: cyc=%b stb=%b we=%b addr=%h ack=%b err=%b, expected zeros", s_cyc_o, s_stb_o, s_we_o, s_addr_o, m0_ack_o, m0_err_o);
    else n_pass++;
    reset = 1'b0;
    model_last = 1;
    bfm_mode = 1; ack_delay = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (m0_ack_o) begin
        acks++;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_txn(0, 1'b1, 32'h010, 32'h3C, xe, xrd);
    n_total++;
    if (acks !== 1) $display("FAIL reset_mid_acks: got %0d pulses, expected 1", acks);
    else n_pass++;
    n_total++;
    if (rom_mem[0][4] !== ref_mem[0][4]) $display("FAIL reset_mid_mem: rom0 word4=%h, expected %h", rom_mem[0][4], ref_mem[0][4]);
    else n_pass++;
    $display("reset_mid: re-granted, acks %0d", acks);
  endtask

  task automatic test_frames();
    logic ga, ge, xe;
    logic [31:0] rd, xrd, addr, data;
    int sc, dc, wr_before;
    bfm_mode = 0;
    wr_before = wr_count;
    for (int i = 0; i < 4; i++) begin
      addr = 32'hC00 + 32'((20 + i) * 4);
      data = 32'($urandom_range(0, 255));
      master_txn(0, 1'b1, addr, data, ga, ge, rd, sc, dc);
      model_txn(0, 1'b1, addr, data, xe, xrd);
      n_total++;
      if (!(ga && !ge && dc - (sc + 1) >= 2 && dc - (sc + 1) <= 9))
        $display("FAIL frame_latency word %0d: ack=%b latency=%0d, expected ack within 9", i, ga, dc - (sc + 1));
      else n_pass++;
      n_total++;
      if (dc % 8 != 1) $display("FAIL frame_align word %0d: ack cycle mod 8 = %0d, expected 1", i, dc % 8);
      else n_pass++;
      $display("frame write word %0d data=%h latency=%0d", i, data[7:0], dc - (sc + 1));
    end
    @(negedge clock);
    n_total++;
    if (wr_count - wr_before !== 4) $display("FAIL frame_writes: rom saw %0d writes, expected 4", wr_count - wr_before);
    else n_pass++;
    for (int i = 0; i < 4; i++) run_single(0, 1'b0, 32'hC00 + 32'((20 + i) * 4), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'h1000 + 32'($urandom_range(0, 255) << 2);
    return 32'($urandom_range(0, NR - 1) << 10) | 32'($urandom_range(0, 7) << 2);
  endfunction

  task automatic test_random();
    int kind;
    bfm_mode = 0;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      if (kind < 2) run_single(kind, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      else run_pair(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) for (int w = 0; w < 256; w++) ref_mem[r][w] = 8'h00;
    test_reset();
    test_write_basic();
    test_fairness();
    test_err_range();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_frames();
    test_random();
    repeat (4) @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      n_total++;
      if (mon_acks[m] !== exp_acks[m]) $display("FAIL total_acks m%0d: saw %0d pulses, expected %0d", m, mon_acks[m], exp_acks[m]);
      else n_pass++;
      n_total++;
      if (mon_errs[m] !== exp_errs[m]) $display("FAIL total_errs m%0d: saw %0d pulses, expected %0d", m, mon_errs[m], exp_errs[m]);
      else n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
